// File: rtl/game_pkg.sv
// Shared definitions for the three-player odd-one-out judge: state encoding,
// winner codes and default game parameters.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_DRAW = 3'b111;

  localparam int TARGET_DEFAULT     = 3;
  localparam int MAX_ROUNDS_DEFAULT = 15;

endpackage

// File: rtl/game_judge_if.sv
// Round-submission handshake: the players' choices qualified by IN_VALID,
// accepted by the judge while it raises IN_READY.
interface game_judge_if;

  logic IN_VALID;
  logic IN_READY;
  logic A_IN;
  logic B_IN;
  logic C_IN;

  modport master (
    output IN_VALID,
    output A_IN,
    output B_IN,
    output C_IN,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  A_IN,
    input  B_IN,
    input  C_IN,
    output IN_READY
  );

endinterface

// File: rtl/odd_one_out.sv
// Flags the single player whose choice differs from the other two; all-equal
// choices yield no point.
module odd_one_out (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [2:0] point
);

  assign point[2] = (a ^ b) & (a ^ c);
  assign point[1] = (b ^ a) & (b ^ c);
  assign point[0] = (c ^ a) & (c ^ b);

endmodule

// File: rtl/game_judge.sv
// Referee for a three-player odd-one-out game: scores each accepted round,
// then decides win, timeout verdict or another round.
module game_judge
  import game_pkg::*;
#(
  parameter int TARGET     = TARGET_DEFAULT,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  game_judge_if.slave  rnd,
  output logic         A_DISP,
  output logic         B_DISP,
  output logic         C_DISP,
  output logic [2:0]   Winner_DISP,
  output logic [3:0]   ROUND
);

  localparam int SW = $clog2(TARGET + 1);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] score_a;
  logic [SW-1:0] score_b;
  logic [SW-1:0] score_c;
  logic [SW-1:0] max_score;
  logic [2:0]    point;
  logic [2:0]    hit;
  logic [2:0]    leaders;
  logic          accept;
  logic          last_round;

  odd_one_out u_odd (
    .a     (rnd.A_IN),
    .b     (rnd.B_IN),
    .c     (rnd.C_IN),
    .point (point)
  );

  assign accept     = rnd.IN_VALID && rnd.IN_READY;
  assign last_round = (ROUND == 4'(MAX_ROUNDS));
  assign hit        = {score_a == SW'(TARGET), score_b == SW'(TARGET), score_c == SW'(TARGET)};

  always_comb begin
    max_score = score_a;
    if (score_b > max_score) max_score = score_b;
    if (score_c > max_score) max_score = score_c;
  end

  // All players sharing the top score are credited; a three-way tie is W_DRAW.
  assign leaders = {score_a == max_score, score_b == max_score, score_c == max_score};

  always_ff @(posedge CLK) begin
    if (!RST) state <= PLAY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY:    if (rnd.IN_VALID) state_next = CHECK;
      CHECK:   state_next = ((|hit) || last_round) ? DONE : PLAY;
      DONE:    if (START) state_next = PLAY;
      default: state_next = PLAY;
    endcase
  end

  always_comb begin
    rnd.IN_READY = (state == PLAY);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      score_a     <= '0;
      score_b     <= '0;
      score_c     <= '0;
      ROUND       <= '0;
      Winner_DISP <= W_NONE;
      A_DISP      <= 1'b0;
      B_DISP      <= 1'b0;
      C_DISP      <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (accept) begin
            A_DISP <= rnd.A_IN;
            B_DISP <= rnd.B_IN;
            C_DISP <= rnd.C_IN;
            ROUND  <= ROUND + 4'd1;
            if (point[2] && (score_a != '1)) score_a <= score_a + 1'b1;
            if (point[1] && (score_b != '1)) score_b <= score_b + 1'b1;
            if (point[0] && (score_c != '1)) score_c <= score_c + 1'b1;
          end
        end
        CHECK: begin
          if (|hit)            Winner_DISP <= hit;
          else if (last_round) Winner_DISP <= leaders;
          else                 Winner_DISP <= W_NONE;
        end
        DONE: begin
          if (START) begin
            score_a     <= '0;
            score_b     <= '0;
            score_c     <= '0;
            ROUND       <= '0;
            Winner_DISP <= W_NONE;
          end
        end
        default: Winner_DISP <= W_NONE;
      endcase
    end
  end

endmodule
